halflife_ctrl: RTL
==================

# halflife_ctrl

Sequencing controller for the 4-bit up/down/load counter of the half-life timer. On `start` it loads an initial quantity into the counter. It then repeatedly halves the counter value, once per programmable period, until the value reaches zero, and reports the number of halvings. When idle it grants the counter to a user up/down requester. It sits between the top-level I/O and the counter and drives the counter's `up`/`down`/`load`/`in` inputs exclusively.

## Interface

Parameters:
- `N`, 4, counter width; also the width of `halvings`.
- `PW`, 8, period timer width.

Ports:
- `clk`, in, 1, sole clock; rising edge.
- `rst`, in, 1, synchronous, active-high reset.
- `start`, in, 1, begin a decay run; sampled in IDLE only.
- `abort`, in, 1, cancel a run; effective in LOAD/WAIT/HALVE.
- `init_val`, in, N, initial quantity; sampled in the cycle `start` is accepted.
- `period`, in, PW, WAIT length in cycles; 0 is treated as 1; sampled on each WAIT entry.
- `usr_up`, in, 1, user increment request.
- `usr_down`, in, 1, user decrement request.
- `cnt_val`, in, N, counter output (feedback).
- `cnt_up`, out, 1, counter increment strobe.
- `cnt_down`, out, 1, counter decrement strobe.
- `cnt_load`, out, 1, counter load strobe.
- `cnt_in`, out, N, counter load data.
- `usr_gnt`, out, 1, a user request is forwarded this cycle.
- `busy`, out, 1, high in LOAD, WAIT and HALVE.
- `done`, out, 1, one-cycle pulse at run completion.
- `halvings`, out, N, halvings performed in the current or last run.

## Operation

- FSM states: IDLE, LOAD, WAIT, HALVE, DONE. Reset state is IDLE.
- IDLE
  - `start`=1: latch `init_val`, go to LOAD.
  - Otherwise: forward user requests (see below).
- LOAD
  - `cnt_load`=1, `cnt_in`=latched `init_val`.
  - Clear `halvings` to 0.
  - Load the timer with max(`period`,1)-1. Go to WAIT.
- WAIT, evaluated in this priority order:
  - `abort` → IDLE.
  - `cnt_val`==0 → DONE.
  - Timer==0 → HALVE.
  - Otherwise decrement the timer.
- HALVE
  - `cnt_load`=1, `cnt_in`=`cnt_val`>>1 (logical shift, MSB filled with 0).
  - `halvings` += 1, saturating at 2^N-1.
  - Reload the timer from `period`. Go to WAIT.
  - `abort` in HALVE: the load still occurs this cycle, `halvings` still increments, next state is IDLE.
- DONE: `done`=1 for one cycle, then IDLE. A `start` seen in DONE is ignored.
- `halvings` holds its value from DONE/abort until the next LOAD.
- User arbitration, active only in IDLE with `start`=0:
  - `usr_up`&~`usr_down` → `cnt_up`=1, `usr_gnt`=1.
  - `usr_down`&~`usr_up` → `cnt_down`=1, `usr_gnt`=1.
  - Both or neither → no strobe, `usr_gnt`=0.
- User requests in any other state are dropped and not queued.
- At most one of `cnt_up`/`cnt_down`/`cnt_load` is high in any cycle.
- `cnt_in`=0 whenever `cnt_load`=0.
- No arithmetic is performed on the counter value other than the shift; counter wrap on user up/down is the counter's own behaviour.

## Timing

- While `rst`=1, all outputs are 0. After reset: state IDLE, timer=0, `halvings`=0.
- `cnt_*`, `usr_gnt`, `busy` and `done` decode combinationally from the state and inputs; all other state is registered.
- Latency:
  - `start` accepted at cycle t → LOAD at t+1 → `cnt_val`=`init_val` visible at t+2 (first WAIT cycle).
  - With P=max(`period`,1), each halving cycle is P WAIT cycles plus 1 HALVE cycle. The new value is visible in the cycle after HALVE.
  - Zero detection → DONE one cycle later.
- `init_val`=0: LOAD, one WAIT cycle (zero detected), DONE. `halvings`=0.
- `rst` mid-run: IDLE next edge, `done` not asserted, `halvings`=0. The counter is not reloaded by this block.
- `abort` and zero detection in the same WAIT cycle: abort wins, no `done`.

## Test plan

- Basic decay: N=4, `init_val`=12, `period`=3, `start` pulse at cycle 0.
  - Required: LOAD at cycle 1; `cnt_load` with `cnt_in`=6,3,1,0 at cycles 5,9,13,17.
  - Required: `done` at cycle 19, `halvings`=4, `busy` high cycles 1–18.
- Period 0 vs 1: `init_val`=2, run once with `period`=0 and once with `period`=1.
  - Required: identical traces, HALVE every 2 cycles, `halvings`=2.
- Zero init: `init_val`=0.
  - Required: LOAD at cycle 1, DONE at cycle 3, `halvings`=0, no HALVE.
- Abort: `init_val`=15, `period`=4, `abort` at the 2nd WAIT cycle after the first HALVE.
  - Required: IDLE next cycle, `done` never pulses, `halvings`=1, `cnt_val`=7 retained.
- Arbitration:
  - In IDLE: `usr_up` → `cnt_up`=1, `usr_gnt`=1; `usr_up`+`usr_down` → no strobe.
  - During WAIT: `usr_down` → no strobe, `usr_gnt`=0.
  - `start`+`usr_up` in the same IDLE cycle → only LOAD follows, no `cnt_up`.
- Reset mid-run: `rst` during HALVE.
  - Required: all outputs 0 while `rst` is high, IDLE afterwards, `halvings`=0, a new `start` runs normally.

Source files
------------

// File: rtl/halflife_ctrl_if.sv
// halflife_ctrl_if
//   Bus between the half-life sequencing controller and the 4-bit
//   up/down/load counter it owns.
//   master (controller side): drives cnt_up, cnt_down, cnt_load, cnt_in;
//                             reads cnt_val.
//   slave  (counter side):    reads the strobes and load data;
//                             drives cnt_val.
interface halflife_ctrl_if #(
  parameter int N = 4
);
  logic         cnt_up;
  logic         cnt_down;
  logic         cnt_load;
  logic [N-1:0] cnt_in;
  logic [N-1:0] cnt_val;

  modport master (
    output cnt_up,
    output cnt_down,
    output cnt_load,
    output cnt_in,
    input  cnt_val
  );

  modport slave (
    input  cnt_up,
    input  cnt_down,
    input  cnt_load,
    input  cnt_in,
    output cnt_val
  );
endinterface

// File: rtl/halflife_ctrl.sv
// halflife_ctrl
//   Sequencing controller for the half-life timer counter. On start it loads
//   init_val into the counter, then halves the counter once every
//   max(period,1) WAIT cycles until it reads zero, counting the halvings.
//   While idle it forwards single-direction user up/down requests.
// Ports
//   clk, rst      : clock, synchronous active-high reset
//   start, abort  : run control
//   init_val      : initial quantity, captured when start is accepted
//   period        : WAIT length in cycles (0 behaves as 1)
//   usr_up/down   : user counter requests (honoured in IDLE only)
//   cnt           : counter bus (strobes, load data, counter feedback)
//   usr_gnt       : user request forwarded this cycle
//   busy          : high in LOAD, WAIT, HALVE
//   done          : one-cycle completion pulse
//   halvings      : halvings performed in the current or last run
module halflife_ctrl #(
  parameter int N  = 4,
  parameter int PW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [N-1:0]    init_val,
  input  logic [PW-1:0]   period,
  input  logic            usr_up,
  input  logic            usr_down,
  halflife_ctrl_if.master cnt,
  output logic            usr_gnt,
  output logic            busy,
  output logic            done,
  output logic [N-1:0]    halvings
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_HALVE,
    S_DONE
  } state_t;

  localparam logic [PW-1:0] TIMER_ONE = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [N-1:0]  HALV_ONE  = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0]  HALV_MAX  = {N{1'b1}};

  state_t        state_q, state_d;
  logic [PW-1:0] timer_q, timer_d;
  logic [N-1:0]  halvings_q, halvings_d;
  logic [N-1:0]  init_q, init_d;

  logic          up_c, down_c, load_c, gnt_c, busy_c, done_c;
  logic [N-1:0]  in_c;

  // A period of 0 runs like 1, so the timer preload is max(p,1)-1.
  function automatic logic [PW-1:0] timer_reload(input logic [PW-1:0] p);
    return (p == '0) ? '0 : (p - TIMER_ONE);
  endfunction

  function automatic logic [N-1:0] sat_inc(input logic [N-1:0] h);
    return (h == HALV_MAX) ? HALV_MAX : (h + HALV_ONE);
  endfunction

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    halvings_d = halvings_q;
    init_d     = init_q;
    up_c       = 1'b0;
    down_c     = 1'b0;
    load_c     = 1'b0;
    in_c       = '0;
    gnt_c      = 1'b0;
    busy_c     = 1'b0;
    done_c     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          init_d  = init_val;
          state_d = S_LOAD;
        end else if (usr_up ^ usr_down) begin
          // Exactly one request: forward it. Both or neither cancel out.
          up_c   = usr_up;
          down_c = usr_down;
          gnt_c  = 1'b1;
        end
      end

      S_LOAD: begin
        busy_c     = 1'b1;
        load_c     = 1'b1;
        in_c       = init_q;
        halvings_d = '0;
        timer_d    = timer_reload(period);
        state_d    = S_WAIT;
      end

      S_WAIT: begin
        busy_c = 1'b1;
        if (abort) begin
          state_d = S_IDLE;
        end else if (cnt.cnt_val == '0) begin
          state_d = S_DONE;
        end else if (timer_q == '0) begin
          state_d = S_HALVE;
        end else begin
          timer_d = timer_q - TIMER_ONE;
        end
      end

      S_HALVE: begin
        // The load and the count update happen even when aborting here.
        busy_c     = 1'b1;
        load_c     = 1'b1;
        in_c       = cnt.cnt_val >> 1;
        halvings_d = sat_inc(halvings_q);
        timer_d    = timer_reload(period);
        state_d    = abort ? S_IDLE : S_WAIT;
      end

      S_DONE: begin
        done_c  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are forced low for the whole reset cycle, not just after it.
    if (rst) begin
      up_c   = 1'b0;
      down_c = 1'b0;
      load_c = 1'b0;
      in_c   = '0;
      gnt_c  = 1'b0;
      busy_c = 1'b0;
      done_c = 1'b0;
    end
  end

  assign cnt.cnt_up   = up_c;
  assign cnt.cnt_down = down_c;
  assign cnt.cnt_load = load_c;
  assign cnt.cnt_in   = in_c;
  assign usr_gnt      = gnt_c;
  assign busy         = busy_c;
  assign done         = done_c;
  assign halvings     = rst ? '0 : halvings_q;

  // Control state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      halvings_q <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      halvings_q <= halvings_d;
    end
  end

  // Captured run data; only read after LOAD, so it needs no reset.
  always_ff @(posedge clk) begin
    init_q <= init_d;
  end

endmodule
